// File: rtl/axi_responder_pkg.sv
// rtl/axi_responder_pkg.sv - shared types and constants for the AXI SRAM responder
package axi_responder_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned ID_W   = 4;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP} resp_state_e;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } axi_ax_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } axi_w_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } axi_r_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } axi_b_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    axi_b_t b;
    logic   b_valid;
    axi_r_t r;
    logic   r_valid;
  } axi_rsp_t;

endpackage

// File: rtl/axi_sram_responder_if.sv
// rtl/axi_sram_responder_if.sv - AXI request/response bundle between interconnect and responder
interface axi_sram_responder_if;
  import axi_responder_pkg::*;

  axi_req_t req;
  axi_rsp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);
endinterface

// File: rtl/axi_sram_responder_addr_gen.sv
// rtl/axi_sram_responder_addr_gen.sv - next beat byte address for FIXED/INCR/WRAP bursts
module axi_burst_addr_gen
  import axi_responder_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        size_i,
  input  logic [7:0]        len_i,
  input  logic [1:0]        burst_i,
  output logic [ADDR_W-1:0] next_addr_o
);
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] mask;

  always_comb begin
    step = ADDR_W'(1) << size_i;
    // wrap window is the whole burst length in bytes
    mask = ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i) - ADDR_W'(1);
    case (burst_i)
      FIXED:   next_addr_o = addr_i;
      WRAP:    next_addr_o = (addr_i & ~mask) | ((addr_i + step) & mask);
      default: next_addr_o = addr_i + step;
    endcase
  end
endmodule

// File: rtl/axi_sram_responder.sv
// rtl/axi_sram_responder.sv - AXI4 responder serving one burst at a time from a 1-cycle SRAM
module axi_sram_responder
  import axi_responder_pkg::*;
#(
  parameter int unsigned NumWords = 4096
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  axi_sram_responder_if.slave         axi,
  output logic                        sram_req_o,
  output logic                        sram_we_o,
  output logic [$clog2(NumWords)-1:0] sram_addr_o,
  output logic [DATA_W-1:0]           sram_wdata_o,
  output logic [STRB_W-1:0]           sram_be_o,
  input  logic [DATA_W-1:0]           sram_rdata_i
);
  localparam int unsigned WORD_W = $clog2(NumWords);
  localparam int unsigned OFFSET = $clog2(STRB_W);

  resp_state_e       state_q, state_d;
  axi_ax_t           ax_q;
  axi_rsp_t          rsp;
  logic [7:0]        cnt_q;
  logic              last_rd_q, wr_err_q, rd_err_q, rd_fresh_q;
  logic [DATA_W-1:0] rdata_q, rd_data_now;
  logic [ADDR_W-1:0] next_addr;
  logic              in_range, beat_last;

  axi_burst_addr_gen u_addr_gen (
    .addr_i     (ax_q.addr),
    .size_i     (ax_q.size),
    .len_i      (ax_q.len),
    .burst_i    (ax_q.burst),
    .next_addr_o(next_addr)
  );

  assign in_range    = (ax_q.addr >> OFFSET) < ADDR_W'(NumWords);
  assign beat_last   = (cnt_q == ax_q.len);
  assign sram_addr_o = ax_q.addr[OFFSET +: WORD_W];
  // data is live from the SRAM on the first R cycle, then replayed from the hold register
  assign rd_data_now = rd_err_q ? '0 : sram_rdata_i;
  assign axi.resp    = rsp;

  always_comb begin
    state_d      = state_q;
    rsp          = '0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_be_o    = '0;
    sram_wdata_o = '0;
    rsp.r.id     = ax_q.id;
    rsp.r.data   = rd_fresh_q ? rd_data_now : rdata_q;
    rsp.r.resp   = rd_err_q ? RESP_SLVERR : RESP_OKAY;
    rsp.r.last   = beat_last;
    rsp.b.id     = ax_q.id;
    rsp.b.resp   = wr_err_q ? RESP_SLVERR : RESP_OKAY;
    case (state_q)
      IDLE: begin
        // on a collision only the channel opposite to the last collision winner is readied
        rsp.ar_ready = axi.req.ar_valid && !(axi.req.aw_valid && last_rd_q);
        rsp.aw_ready = axi.req.aw_valid && !(axi.req.ar_valid && !last_rd_q);
        if (rsp.ar_ready)      state_d = RD_REQ;
        else if (rsp.aw_ready) state_d = WR_DATA;
      end
      RD_REQ: begin
        sram_req_o = in_range;
        state_d    = RD_DATA;
      end
      RD_DATA: begin
        rsp.r_valid = 1'b1;
        if (axi.req.r_ready) state_d = beat_last ? IDLE : RD_REQ;
      end
      WR_DATA: begin
        rsp.w_ready = 1'b1;
        if (axi.req.w_valid) begin
          sram_req_o   = in_range;
          sram_we_o    = 1'b1;
          sram_be_o    = axi.req.w.strb;
          sram_wdata_o = axi.req.w.data;
          if (beat_last) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        rsp.b_valid = 1'b1;
        if (axi.req.b_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ax_q       <= '0;
      cnt_q      <= '0;
      last_rd_q  <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_fresh_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rd_fresh_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rsp.ar_ready) begin
            ax_q  <= axi.req.ar;
            cnt_q <= '0;
            if (axi.req.aw_valid) last_rd_q <= 1'b1;
          end else if (rsp.aw_ready) begin
            ax_q     <= axi.req.aw;
            cnt_q    <= '0;
            wr_err_q <= 1'b0;
            if (axi.req.ar_valid) last_rd_q <= 1'b0;
          end
        end
        RD_REQ: begin
          rd_err_q   <= !in_range;
          rd_fresh_q <= 1'b1;
        end
        RD_DATA: begin
          if (rd_fresh_q) rdata_q <= rd_data_now;
          if (axi.req.r_ready && !beat_last) begin
            ax_q.addr <= next_addr;
            cnt_q     <= cnt_q + 8'd1;
          end
        end
        WR_DATA: begin
          if (axi.req.w_valid) begin
            if (!in_range) wr_err_q <= 1'b1;
            ax_q.addr <= next_addr;
            cnt_q     <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  w_last_matches_len: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == WR_DATA && axi.req.w_valid) |-> (axi.req.w.last == beat_last));

endmodule
